// File: rtl/siren_pkg.sv
// Shared encodings and helpers for the two-tone siren generator.
package siren_pkg;

  typedef enum logic [1:0] {
    MODE_TONE  = 2'b00,
    MODE_SIREN = 2'b01,
    MODE_BEEP  = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEG1 = 2'b01,
    ST_SEG2 = 2'b10
  } state_t;

  // Half-period of a square wave at freq_hz, in clock cycles.
  function automatic int half_period(input int clk_hz, input int freq_hz);
    return clk_hz / freq_hz / 2;
  endfunction

endpackage

// File: rtl/siren_tone_gen_divider.sv
// Half-period square-wave divider; clr restarts the phase with sq low.
module tone_divider #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] half,
  output logic             sq
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr || !en) begin
      cnt <= '0;
      sq  <= 1'b0;
    end else if (cnt == half - DIV_W'(1)) begin
      cnt <= '0;
      sq  <= ~sq;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/siren_tone_gen.sv
// Cadenced two-tone alarm: tone A / A-B siren / A-beep patterns driving one speaker pin.
module siren_tone_gen
  import siren_pkg::*;
#(
  parameter int CLK_HZ   = 10_000_000,
  parameter int FREQ_A   = 400,
  parameter int FREQ_B   = 300,
  parameter int SEG_CLKS = 5_000_000,
  parameter int DIV_W    = 16,
  parameter int SEG_W    = 24,
  parameter int REPS_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [REPS_W-1:0] reps,
  output logic              spk,
  output logic              busy,
  output logic              done,
  output logic              tone_b
);

  localparam logic [DIV_W-1:0] HALF_A = DIV_W'(half_period(CLK_HZ, FREQ_A));
  localparam logic [DIV_W-1:0] HALF_B = DIV_W'(half_period(CLK_HZ, FREQ_B));

  state_t            state;
  mode_t             mode_l;
  logic [REPS_W-1:0] reps_l, pair_cnt, pair_nxt;
  logic [SEG_W-1:0]  seg_cnt;
  logic              seg_last, div_clr, div_en;
  logic [DIV_W-1:0]  div_half;

  assign seg_last = (seg_cnt == SEG_W'(SEG_CLKS - 1));
  assign pair_nxt = pair_cnt + REPS_W'(1);

  // Divider phase restarts on accepted start, every segment boundary and stop.
  always_comb begin
    div_clr  = 1'b0;
    div_en   = 1'b0;
    div_half = HALF_A;
    if (state == ST_IDLE) begin
      div_clr = start && !stop;
    end else begin
      div_clr = stop || seg_last;
    end
    if (state == ST_SEG1) div_en = 1'b1;
    if (state == ST_SEG2) begin
      div_en = (mode_l != MODE_BEEP);
      if (mode_l == MODE_SIREN) div_half = HALF_B;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      mode_l   <= MODE_TONE;
      reps_l   <= '0;
      pair_cnt <= '0;
      seg_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tone_b   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            state    <= ST_SEG1;
            mode_l   <= (mode == 2'b11) ? MODE_SIREN : mode_t'(mode);
            reps_l   <= reps;
            pair_cnt <= '0;
            seg_cnt  <= '0;
            busy     <= 1'b1;
          end
        end
        default: begin
          if (stop) begin
            state   <= ST_IDLE;
            seg_cnt <= '0;
            busy    <= 1'b0;
            tone_b  <= 1'b0;
          end else if (seg_last) begin
            seg_cnt <= '0;
            if (state == ST_SEG1) begin
              state  <= ST_SEG2;
              tone_b <= (mode_l == MODE_SIREN);
            end else begin
              tone_b   <= 1'b0;
              pair_cnt <= pair_nxt;
              if (reps_l != '0 && pair_nxt == reps_l) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= ST_SEG1;
              end
            end
          end else begin
            seg_cnt <= seg_cnt + SEG_W'(1);
          end
        end
      endcase
    end
  end

  tone_divider #(.DIV_W(DIV_W)) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (div_clr),
    .en   (div_en),
    .half (div_half),
    .sq   (spk)
  );

endmodule
